dmi_jtag_sequencer: RTL and testbench

DMI_JTAG_SEQUENCER -- requirements
Module: dmi_jtag_sequencer

---
 rtl/dmi_jtag_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_dmi_jtag_sequencer.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmi_jtag_sequencer.sv
// -----------------------------------------------------------------------------
// dm_pkg -- DMI request/response types shared by the JTAG DTM and the debug
// module side of the CDC FIFOs.
//
// dmi_jtag_sequencer -- TCK-domain sequencer that turns scanned DMI register
// updates into single request/response transactions towards the CDC FIFOs and
// keeps the sticky DMI status reported back on the next capture.
//
// Ports
//   clk_i, rst_i          TCK clock, asynchronous active-high reset
//   update_i              strobe: new DMI scan value (addr/data/op) present
//   update_addr_i/_data_i/_op_i  scanned fields (op: 0 NOP, 1 READ, 2 WRITE)
//   capture_i             strobe: DMI scan register is being captured
//   dmi_clear_i           clear the sticky status (dmireset)
//   dmi_hard_reset_i      abort the transaction and clear status (dmihardreset)
//   capture_addr_o/_data_o  address and data of the last transaction
//   capture_status_o      sticky status: 0 ok, 2 failed, 3 busy
//   dmi_req_o/_valid_o/_ready_i    request handshake to the CDC request FIFO
//   dmi_resp_i/_valid_i/_ready_o   response handshake from the CDC response FIFO
// -----------------------------------------------------------------------------
package dm_pkg;

  localparam logic [1:0] DTM_NOP   = 2'h0;
  localparam logic [1:0] DTM_READ  = 2'h1;
  localparam logic [1:0] DTM_WRITE = 2'h2;

  localparam logic [1:0] DMI_ERR_NONE   = 2'h0;
  localparam logic [1:0] DMI_ERR_FAILED = 2'h2;
  localparam logic [1:0] DMI_ERR_BUSY   = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

module dmi_jtag_sequencer #(
  // Must match the width of dm_pkg::dmi_req_t.addr.
  parameter int unsigned AddrWidth = 7
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 update_i,
  input  logic [AddrWidth-1:0] update_addr_i,
  input  logic [31:0]          update_data_i,
  input  logic [1:0]           update_op_i,
  input  logic                 capture_i,
  input  logic                 dmi_clear_i,
  input  logic                 dmi_hard_reset_i,

  output logic [AddrWidth-1:0] capture_addr_o,
  output logic [31:0]          capture_data_o,
  output logic [1:0]           capture_status_o,

  output dm_pkg::dmi_req_t     dmi_req_o,
  output logic                 dmi_req_valid_o,
  input  logic                 dmi_req_ready_i,

  input  dm_pkg::dmi_resp_t    dmi_resp_i,
  input  logic                 dmi_resp_valid_i,
  output logic                 dmi_resp_ready_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_READ,
    WAIT_READ,
    REQ_WRITE,
    WAIT_WRITE
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] addr_q;
  // Holds the write data while a write is outstanding, and the read data once
  // a read has completed; it feeds both the request and the capture port.
  logic [31:0]          data_q;
  logic [1:0]           op_q;
  logic [1:0]           error_q;
  logic                 req_valid_q;
  logic                 resp_ready_q;

  // ---------------------------------------------------------------------------
  // Event decode
  // ---------------------------------------------------------------------------
  logic in_idle;
  logic in_wait;
  logic no_error;
  logic busy_event;
  logic resp_hs;
  logic resp_fail;
  logic start_read;
  logic start_write;

  assign in_idle  = (state_q == IDLE);
  assign in_wait  = (state_q == WAIT_READ) || (state_q == WAIT_WRITE);
  assign no_error = (error_q == dm_pkg::DMI_ERR_NONE);

  // A scan access while a transaction is still in flight means the debugger
  // is going too fast; the in-flight transaction itself is left alone.
  assign busy_event = (update_i || capture_i) && !in_idle;

  assign resp_hs   = dmi_resp_valid_i && resp_ready_q;
  assign resp_fail = resp_hs && in_wait && (dmi_resp_i.resp != 2'b00);

  // Once the status is sticky-nonzero, new updates are dropped entirely.
  assign start_read  = update_i && in_idle && no_error && (update_op_i == dm_pkg::DTM_READ);
  assign start_write = update_i && in_idle && no_error && (update_op_i == dm_pkg::DTM_WRITE);

  // ---------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: every register here, including the datapath, sits on the async reset
  // so the request bus and capture ports read all-zero the instant rst_i rises.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      op_q         <= dm_pkg::DTM_NOP;
      error_q      <= dm_pkg::DMI_ERR_NONE;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b1;
    end else if (dmi_hard_reset_i) begin
      // Abort wins over everything, including a same-cycle update. The latched
      // address/data are kept so the capture port still shows the last access.
      state_q      <= IDLE;
      error_q      <= dm_pkg::DMI_ERR_NONE;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b1;
    end else begin
      // Sticky status: clear beats any simultaneous error; the first error
      // recorded is never overwritten. Busy outranks a same-cycle failed resp.
      // NOTE: non-blocking assignments keep every register sampling the values
      // from before this edge, independent of statement order.
      if (dmi_clear_i) begin
        error_q <= dm_pkg::DMI_ERR_NONE;
      end else if (no_error) begin
        if (busy_event) begin
          error_q <= dm_pkg::DMI_ERR_BUSY;
        end else if (resp_fail) begin
          error_q <= dm_pkg::DMI_ERR_FAILED;
        end
      end

      unique case (state_q)
        IDLE: begin
          // Responses arriving here are drained (resp_ready is 1) and dropped.
          if (start_read) begin
            addr_q       <= update_addr_i;
            data_q       <= '0;
            op_q         <= dm_pkg::DTM_READ;
            state_q      <= REQ_READ;
            req_valid_q  <= 1'b1;
            resp_ready_q <= 1'b0;
          end else if (start_write) begin
            addr_q       <= update_addr_i;
            data_q       <= update_data_i;
            op_q         <= dm_pkg::DTM_WRITE;
            state_q      <= REQ_WRITE;
            req_valid_q  <= 1'b1;
            resp_ready_q <= 1'b0;
          end
        end

        REQ_READ, REQ_WRITE: begin
          // Request fields come straight from the latched registers, so they
          // cannot move while the FIFO back-pressures.
          if (dmi_req_ready_i) begin
            state_q      <= (state_q == REQ_READ) ? WAIT_READ : WAIT_WRITE;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b1;
          end
        end

        WAIT_READ: begin
          if (dmi_resp_valid_i) begin
            data_q  <= dmi_resp_i.data;
            state_q <= IDLE;
          end
        end

        WAIT_WRITE: begin
          if (dmi_resp_valid_i) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q      <= IDLE;
          req_valid_q  <= 1'b0;
          resp_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign capture_addr_o   = addr_q;
  assign capture_data_o   = data_q;
  assign capture_status_o = error_q;

  assign dmi_req_o        = '{addr: addr_q, op: op_q, data: data_q};
  assign dmi_req_valid_o  = req_valid_q;
  assign dmi_resp_ready_o = resp_ready_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // Request and response handshakes are never open at the same time.
  a_valid_xor_ready: assert property (
    @(posedge clk_i) disable iff (rst_i) req_valid_q != resp_ready_q);

  // Valid tracks the request states exactly.
  a_valid_state: assert property (
    @(posedge clk_i) disable iff (rst_i)
    req_valid_q == ((state_q == REQ_READ) || (state_q == REQ_WRITE)));

  // A back-pressured request holds still unless aborted.
  a_req_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (req_valid_q && !dmi_req_ready_i && !dmi_hard_reset_i)
    |=> (req_valid_q && $stable(dmi_req_o)));

endmodule

// File: tb/tb_dmi_jtag_sequencer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for dmi_jtag_sequencer: a directed vector table, hand
// sequences for the multi-cycle corners, then randomized traffic. A
// transaction-level reference model shadows the DUT on every clock.
// -----------------------------------------------------------------------------
module tb_dmi_jtag_sequencer;

  localparam int AW = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              update;
  logic [AW-1:0]     update_addr;
  logic [31:0]       update_data;
  logic [1:0]        update_op;
  logic              capture;
  logic              dmi_clear;
  logic              dmi_hard_reset;
  logic [AW-1:0]     capture_addr;
  logic [31:0]       capture_data;
  logic [1:0]        capture_status;
  dm_pkg::dmi_req_t  dmi_req;
  logic              dmi_req_valid;
  logic              dmi_req_ready;
  dm_pkg::dmi_resp_t dmi_resp;
  logic              dmi_resp_valid;
  logic              dmi_resp_ready;

  always #5 clk = ~clk;

  dmi_jtag_sequencer #(.AddrWidth(AW)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .update_i         (update),
    .update_addr_i    (update_addr),
    .update_data_i    (update_data),
    .update_op_i      (update_op),
    .capture_i        (capture),
    .dmi_clear_i      (dmi_clear),
    .dmi_hard_reset_i (dmi_hard_reset),
    .capture_addr_o   (capture_addr),
    .capture_data_o   (capture_data),
    .capture_status_o (capture_status),
    .dmi_req_o        (dmi_req),
    .dmi_req_valid_o  (dmi_req_valid),
    .dmi_req_ready_i  (dmi_req_ready),
    .dmi_resp_i       (dmi_resp),
    .dmi_resp_valid_i (dmi_resp_valid),
    .dmi_resp_ready_o (dmi_resp_ready)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one outstanding transaction, described by whether it
  // exists, whether its request was taken, and whether it is a read.
  // ---------------------------------------------------------------------------
  bit          m_active;
  bit          m_accepted;
  bit          m_is_read;
  logic [6:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_op;
  logic [1:0]  m_err;

  function automatic void model_reset();
    m_active   = 1'b0;
    m_accepted = 1'b0;
    m_is_read  = 1'b0;
    m_addr     = '0;
    m_data     = '0;
    m_op       = 2'd0;
    m_err      = 2'd0;
  endfunction

  // Applies the rules for one clock edge using the inputs currently driven.
  function automatic void model_step();
    logic [1:0] err_old;
    err_old = m_err;
    if (dmi_hard_reset) begin
      m_active   = 1'b0;
      m_accepted = 1'b0;
      m_err      = 2'd0;
      return;
    end
    if (dmi_clear) begin
      m_err = 2'd0;
    end else if (err_old == 2'd0) begin
      if ((update || capture) && m_active)
        m_err = 2'd3;
      else if (m_active && m_accepted && dmi_resp_valid && dmi_resp.resp != 2'd0)
        m_err = 2'd2;
    end
    if (!m_active) begin
      if (update && err_old == 2'd0 && (update_op == 2'd1 || update_op == 2'd2)) begin
        m_active   = 1'b1;
        m_accepted = 1'b0;
        m_is_read  = (update_op == 2'd1);
        m_addr     = update_addr;
        m_op       = update_op;
        m_data     = m_is_read ? 32'd0 : update_data;
      end
    end else if (!m_accepted) begin
      if (dmi_req_ready) m_accepted = 1'b1;
    end else if (dmi_resp_valid) begin
      if (m_is_read) m_data = dmi_resp.data;
      m_active = 1'b0;
    end
  endfunction

  task automatic compare_model();
    logic exp_valid;
    exp_valid = m_active && !m_accepted;
    check("mdl_req_valid",  dmi_req_valid,  exp_valid);
    check("mdl_resp_ready", dmi_resp_ready, !exp_valid);
    check("mdl_status",     capture_status, m_err);
    check("mdl_cap_addr",   capture_addr,   m_addr);
    check("mdl_cap_data",   capture_data,   m_data);
    check("mdl_req_addr",   dmi_req.addr,   m_addr);
    check("mdl_req_data",   dmi_req.data,   m_data);
    check("mdl_req_op",     dmi_req.op,     m_op);
  endtask

  // One clock: model consumes the same inputs the DUT sees, outputs are
  // compared 1 time unit after the edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic clear_inputs();
    update         = 1'b0;
    update_addr    = '0;
    update_data    = '0;
    update_op      = 2'd0;
    capture        = 1'b0;
    dmi_clear      = 1'b0;
    dmi_hard_reset = 1'b0;
    dmi_req_ready  = 1'b0;
    dmi_resp_valid = 1'b0;
    dmi_resp       = '0;
  endtask

  task automatic do_update(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    update      = 1'b1;
    update_op   = op;
    update_addr = addr;
    update_data = data;
  endtask

  task automatic do_resp(input logic [31:0] data, input logic [1:0] resp);
    dmi_resp_valid = 1'b1;
    dmi_resp.data  = data;
    dmi_resp.resp  = resp;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},  dmi_req_valid,  1'b0);
    check({tag, "_rready"}, dmi_resp_ready, 1'b1);
    check({tag, "_addr"},   capture_addr,   7'd0);
    check({tag, "_data"},   capture_data,   32'd0);
    check({tag, "_status"}, capture_status, 2'd0);
    check({tag, "_req"},    dmi_req,        41'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: inputs applied for one clock, outputs expected after it.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        upd;
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    logic        cap;
    logic        clr;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        e_valid;
    logic [1:0]  e_status;
    logic [1:0]  e_op;
    logic [6:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    //          upd   op     addr    data          cap   clr   rdy   rv    rdata         rresp  valid stat   op     addr    data
    vecs[0]  = '{1'b1, 2'd1, 7'h10, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b1, 2'd0, 2'd1, 7'h10, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'd0, 1'b0, 2'd0, 2'd1, 7'h10, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd0, 2'd1, 7'h10, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 2'd0, 1'b0, 2'd0, 2'd1, 7'h10, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 2'd2, 7'h04, 32'h1234,      1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'd0, 1'b1, 2'd0, 2'd2, 7'h04, 32'h1234};
    vecs[5]  = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         2'd0, 1'b0, 2'd0, 2'd2, 7'h04, 32'h1234};
    vecs[6]  = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd3, 2'd2, 7'h04, 32'h1234};
    vecs[7]  = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF,      2'd0, 1'b0, 2'd3, 2'd2, 7'h04, 32'h1234};
    vecs[8]  = '{1'b1, 2'd1, 7'h11, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd3, 2'd2, 7'h04, 32'h1234};
    vecs[9]  = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd0, 2'd2, 7'h04, 32'h1234};
    vecs[10] = '{1'b1, 2'd0, 7'h33, 32'h77,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd0, 2'd2, 7'h04, 32'h1234};
    vecs[11] = '{1'b1, 2'd3, 7'h33, 32'h77,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd0, 2'd2, 7'h04, 32'h1234};
    vecs[12] = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hAAAA,      2'd0, 1'b0, 2'd0, 2'd2, 7'h04, 32'h1234};
    vecs[13] = '{1'b1, 2'd1, 7'h22, 32'h99,        1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b1, 2'd0, 2'd1, 7'h22, 32'h0};
    vecs[14] = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b1, 1'b1, 32'h5555,      2'd0, 1'b0, 2'd0, 2'd1, 7'h22, 32'h0};
    vecs[15] = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h5555,      2'd1, 1'b0, 2'd2, 2'd1, 7'h22, 32'h5555};
    vecs[16] = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd2, 2'd1, 7'h22, 32'h5555};
    vecs[17] = '{1'b0, 2'd0, 7'h00, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         2'd0, 1'b0, 2'd0, 2'd1, 7'h22, 32'h5555};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    // Directed table; row 0 lands on the very first edge after reset release.
    for (int i = 0; i < NV; i++) begin
      clear_inputs();
      update         = vecs[i].upd;
      update_op      = vecs[i].op;
      update_addr    = vecs[i].addr;
      update_data    = vecs[i].data;
      capture        = vecs[i].cap;
      dmi_clear      = vecs[i].clr;
      dmi_req_ready  = vecs[i].rdy;
      dmi_resp_valid = vecs[i].rv;
      dmi_resp.data  = vecs[i].rdata;
      dmi_resp.resp  = vecs[i].rresp;
      step();
      check($sformatf("vec%0d_valid", i),  dmi_req_valid,  vecs[i].e_valid);
      check($sformatf("vec%0d_rready", i), dmi_resp_ready, !vecs[i].e_valid);
      check($sformatf("vec%0d_status", i), capture_status, vecs[i].e_status);
      check($sformatf("vec%0d_op", i),     dmi_req.op,     vecs[i].e_op);
      check($sformatf("vec%0d_addr", i),   capture_addr,   vecs[i].e_addr);
      check($sformatf("vec%0d_data", i),   capture_data,   vecs[i].e_data);
    end

    // Read with ready held high, response three cycles after acceptance.
    clear_inputs();
    dmi_req_ready = 1'b1;
    do_update(2'd1, 7'h10, 32'h0);
    step();
    check("rd_valid_after_1", dmi_req_valid, 1'b1);
    check("rd_req_addr", dmi_req.addr, 7'h10);
    update = 1'b0;
    step();
    check("rd_valid_dropped", dmi_req_valid, 1'b0);
    step();
    step();
    do_resp(32'hDEAD_BEEF, 2'd0);
    step();
    check("rd_data", capture_data, 32'hDEAD_BEEF);
    check("rd_status", capture_status, 2'd0);

    // Write stalled by ready=0 for five cycles, then a failing response.
    clear_inputs();
    do_update(2'd2, 7'h04, 32'h1234);
    step();
    update = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("wr_stall%0d_valid", i), dmi_req_valid, 1'b1);
      check($sformatf("wr_stall%0d_req", i), dmi_req, {7'h04, 2'd2, 32'h1234});
      step();
    end
    check("wr_stall_end_valid", dmi_req_valid, 1'b1);
    dmi_req_ready = 1'b1;
    step();
    dmi_req_ready = 1'b0;
    do_resp(32'hBAD0_BAD0, 2'd2);
    step();
    check("wr_fail_status", capture_status, 2'd2);
    check("wr_fail_data", capture_data, 32'h1234);
    clear_inputs();
    dmi_clear = 1'b1;
    step();

    // Second update during WAIT_READ -> busy; later updates dropped until clear.
    clear_inputs();
    dmi_req_ready = 1'b1;
    do_update(2'd1, 7'h05, 32'h0);
    step();
    update = 1'b0;
    step();
    do_update(2'd1, 7'h06, 32'h0);
    step();
    check("busy_status", capture_status, 2'd3);
    check("busy_no_req", dmi_req_valid, 1'b0);
    update = 1'b0;
    step();
    check("busy_no_req2", dmi_req_valid, 1'b0);
    do_resp(32'hCAFE_F00D, 2'd0);
    step();
    check("busy_first_data", capture_data, 32'hCAFE_F00D);
    check("busy_first_addr", capture_addr, 7'h05);
    dmi_resp_valid = 1'b0;
    do_update(2'd1, 7'h07, 32'h0);
    step();
    check("busy_upd_ignored", dmi_req_valid, 1'b0);
    check("busy_addr_kept", capture_addr, 7'h05);
    update    = 1'b0;
    dmi_clear = 1'b1;
    step();
    check("busy_cleared", capture_status, 2'd0);
    dmi_clear = 1'b0;
    do_update(2'd1, 7'h07, 32'h0);
    step();
    check("busy_next_read", dmi_req_valid, 1'b1);
    check("busy_next_addr", dmi_req.addr, 7'h07);
    update = 1'b0;
    step();
    do_resp(32'h0000_0001, 2'd0);
    step();

    // Hard reset during REQ_WRITE, stray response drained, hard beats update.
    clear_inputs();
    do_update(2'd2, 7'h08, 32'hBEEF);
    step();
    check("hr_valid_before", dmi_req_valid, 1'b1);
    update         = 1'b0;
    dmi_hard_reset = 1'b1;
    dmi_req_ready  = 1'b1;
    step();
    check("hr_valid_dropped", dmi_req_valid, 1'b0);
    check("hr_rready", dmi_resp_ready, 1'b1);
    check("hr_status", capture_status, 2'd0);
    dmi_hard_reset = 1'b0;
    dmi_req_ready  = 1'b0;
    do_resp(32'h1111_1111, 2'd1);
    step();
    check("hr_stray_data", capture_data, 32'hBEEF);
    check("hr_stray_status", capture_status, 2'd0);
    dmi_resp_valid = 1'b0;
    dmi_hard_reset = 1'b1;
    do_update(2'd1, 7'h09, 32'h0);
    step();
    check("hr_update_dropped", dmi_req_valid, 1'b0);
    check("hr_update_addr", capture_addr, 7'h08);

    // Clear coinciding with a busy-causing capture: clear wins.
    clear_inputs();
    do_update(2'd1, 7'h0A, 32'h0);
    step();
    update    = 1'b0;
    capture   = 1'b1;
    dmi_clear = 1'b1;
    step();
    check("clr_vs_busy", capture_status, 2'd0);
    dmi_clear = 1'b0;
    step();
    check("capture_busy", capture_status, 2'd3);
    capture   = 1'b0;
    dmi_clear = 1'b1;
    dmi_req_ready = 1'b1;
    step();
    check("capture_busy_cleared", capture_status, 2'd0);
    dmi_clear = 1'b0;
    dmi_req_ready = 1'b0;
    do_resp(32'h0A0A_0A0A, 2'd0);
    step();
    check("capture_inflight_data", capture_data, 32'h0A0A_0A0A);

    // Asynchronous reset in WAIT_READ, observed before any clock edge.
    clear_inputs();
    dmi_req_ready = 1'b1;
    do_update(2'd1, 7'h0B, 32'h0);
    step();
    update = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
    do_resp(32'h7777_7777, 2'd0);
    step();
    check("post_rst_no_capture", capture_data, 32'd0);
    check("post_rst_no_req", dmi_req_valid, 1'b0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 2000; c++) begin
      update         = ($urandom_range(0, 3) == 0);
      update_op      = 2'($urandom_range(0, 3));
      update_addr    = 7'($urandom);
      update_data    = $urandom;
      capture        = ($urandom_range(0, 15) == 0);
      dmi_clear      = ($urandom_range(0, 11) == 0);
      dmi_hard_reset = ($urandom_range(0, 49) == 0);
      dmi_req_ready  = 1'($urandom_range(0, 1));
      dmi_resp_valid = ($urandom_range(0, 2) == 0);
      dmi_resp.data  = $urandom;
      dmi_resp.resp  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
